lif_layer_scheduler: RTL and testbench
======================================

Name: lif_layer_scheduler

Overview:
Time-multiplexed LIF layer engine. One shared LIF update datapath serves NUM_NEURONS neurons across NUM_TIMESTEPS timesteps. Per-neuron membrane, reset-delay and spike-count state live in internal arrays. Per-neuron input currents are loaded through a write port. On start, the block sweeps timesteps in the outer loop and neurons in the inner loop, and streams each update out over a valid/ready interface. It sits between the fully-connected current stage and the spike-count readout of the CartPole SNN.

Parameters:
NUM_NEURONS, 16, neurons sharing the datapath (>=2)
NUM_TIMESTEPS, 30, timesteps per inference (>=2)
THRESHOLD, 8192, spike threshold, QS2.13 (1.0)
BETA, 115, decay factor, Q1.7 (~0.9)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cur_we  in  1  current buffer write enable (honoured only when busy=0)
cur_addr  in  $clog2(NUM_NEURONS)  neuron index for write
cur_data  in  16  signed QS2.13 input current
start  in  1  begin inference (honoured only when busy=0)
busy  out  1  inference in progress
done  out  1  one-cycle pulse at inference completion
out_valid  out  1  update result valid
out_ready  in  1  downstream accepts result
out_neuron  out  $clog2(NUM_NEURONS)  neuron index of result
out_timestep  out  $clog2(NUM_TIMESTEPS)  timestep of result
out_spike  out  1  spike for this neuron/timestep
out_membrane  out  24  signed membrane after update
cnt_addr  in  $clog2(NUM_NEURONS)  spike-count read index
cnt_data  out  $clog2(NUM_TIMESTEPS+1)  spike count, registered, 1-cycle read latency

Behaviour:
- Reset (synchronous): FSM goes to IDLE. All outputs go to 0. Current buffer, membranes, spike_prev bits and counts are cleared. Reset overrides all other inputs, including mid-run.
- FSM states: IDLE -> CLEAR -> RUN -> FLUSH -> IDLE.
- IDLE: busy=0.
  - cur_we writes cur_data to buffer[cur_addr].
  - start moves to CLEAR.
  - If start and cur_we occur in the same cycle, the write commits and the run uses the new value.
- CLEAR: N cycles, one neuron per cycle. Zeroes membrane[i], spike_prev[i] and count[i]. busy=1.
- Timing from start sampled in cycle k:
  - busy=1 from k+1.
  - CLEAR occupies k+1..k+N.
  - RUN begins at k+N+1.
  - First out_valid appears at k+N+2.
- RUN: one update issues per cycle when (!out_valid || out_ready). Otherwise state and indices hold and output registers are stable.
- Update for neuron n at timestep t, using the buffer current (sign-extended to 24 bits):
  - decay = 24'((membrane[n] * BETA) >>> 7), 32-bit product, arithmetic shift.
  - next = decay + current - (spike_prev[n] ? THRESHOLD : 0).
  - spike = (next >= THRESHOLD), signed compare.
- Each issue writes back:
  - membrane[n] <= next.
  - spike_prev[n] <= spike. spike_prev is always 0 at t=0, since CLEAR zeroes it.
  - count[n] increments if spike. The counter cannot overflow.
  - The output registers are loaded with n, t, spike, next, and out_valid <= 1.
- Index advance: n increments each issue. At n=N-1 it wraps to 0 and t increments. Issuing (N-1, T-1) moves the FSM to FLUSH.
- FLUSH: waits for the final handshake (out_valid && out_ready). In the following cycle: done=1, busy=0, out_valid=0, state returns to IDLE.
- With out_ready held at 1: out_valid is high continuously for N*T cycles, and done pulses the cycle after the last beat.
- out_valid never drops without a handshake.
- Ignored inputs: cur_we and start while busy=1 (buffer unchanged, no restart).
- Counts are retained after done until the next start's CLEAR. cnt_data is readable in any state.
- A result held under backpressure must not be overwritten.

Test Plan:
- N=4, T=3, all currents 8192, out_ready=1 -> each neuron produces (t0: mem 8192, spike 1), (t1: 7360, 0), (t2: 14804, 1). Beat order is n0..n3 per t. done pulses once, the cycle after beat 12. cnt_data=2 for every neuron.
- Current -4096 on neuron 1, 0 on the others -> neuron 1 gives mem -4096 then -7776, never spikes. Neurons with 0 current stay at mem 0. Counts are 0.
- Random out_ready toggling -> beat sequence and values are identical to the out_ready=1 run. out_* is stable while out_valid && !out_ready. No beat is lost or duplicated.
- start and cur_we pulsed mid-run -> no restart, buffer unchanged, results identical to an undisturbed run. A start in the cycle after done begins a fresh run with counts re-cleared.
- reset asserted mid-RUN, then currents reloaded and start -> busy, out_valid and done are 0 the cycle after reset. The new run matches a run from power-on.
- Back-to-back inferences with different currents -> the second run's t0 membranes equal its currents exactly, so no state carries over.

Source files
------------

// File: rtl/lif_layer_scheduler.sv
// rtl/lif_layer_scheduler.sv - time-multiplexed LIF layer engine with streamed per-update results
//
// One shared LIF update datapath serves NUM_NEURONS neurons over NUM_TIMESTEPS timesteps.
// Timesteps form the outer loop and neurons the inner loop. Each update is streamed out
// over a valid/ready interface. Membrane, previous-spike and spike-count state are kept
// per neuron in internal arrays.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset
//   i_cur_we       current buffer write enable (only while idle)
//   i_cur_addr     neuron index for current write
//   i_cur_data     signed QS2.13 input current
//   i_start        begin inference (only while idle)
//   o_busy         inference in progress
//   o_done         one-cycle pulse at inference completion
//   o_out_valid    update result valid
//   i_out_ready    downstream accepts result
//   o_out_neuron   neuron index of result
//   o_out_timestep timestep of result
//   o_out_spike    spike for this neuron/timestep
//   o_out_membrane signed membrane after update
//   i_cnt_addr     spike-count read index
//   o_cnt_data     spike count, registered, 1-cycle read latency
module lif_layer_scheduler #(
  parameter int NUM_NEURONS   = 16,
  parameter int NUM_TIMESTEPS = 30,
  parameter int THRESHOLD     = 8192,
  parameter int BETA          = 115,
  localparam int NW = $clog2(NUM_NEURONS),
  localparam int TW = $clog2(NUM_TIMESTEPS),
  localparam int CW = $clog2(NUM_TIMESTEPS + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cur_we,
  input  logic [NW-1:0] i_cur_addr,
  input  logic [15:0]   i_cur_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [NW-1:0] o_out_neuron,
  output logic [TW-1:0] o_out_timestep,
  output logic          o_out_spike,
  output logic [23:0]   o_out_membrane,
  input  logic [NW-1:0] i_cnt_addr,
  output logic [CW-1:0] o_cnt_data
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH} state_t;

  localparam logic signed [31:0] BETA_S = 32'(BETA);
  localparam logic signed [23:0] THR_S  = 24'(THRESHOLD);

  state_t r_state, w_next_state;
  logic   w_busy;

  logic [NW-1:0]          r_n;
  logic [TW-1:0]          r_t;
  logic signed [15:0]     r_cur  [NUM_NEURONS];
  logic signed [23:0]     r_mem  [NUM_NEURONS];
  logic [CW-1:0]          r_count[NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_spike_prev;

  logic          r_out_valid;
  logic [NW-1:0] r_out_neuron;
  logic [TW-1:0] r_out_timestep;
  logic          r_out_spike;
  logic [23:0]   r_out_membrane;
  logic          r_done;
  logic [CW-1:0] r_cnt_data;

  logic w_last_n, w_last_t, w_issue, w_handshake;
  logic signed [31:0] w_mem_ext, w_prod;
  logic signed [23:0] w_decay, w_cur_ext, w_next;
  logic               w_spike;

  assign w_last_n    = (r_n == NW'(NUM_NEURONS - 1));
  assign w_last_t    = (r_t == TW'(NUM_TIMESTEPS - 1));
  // An update may only issue when the output register is empty or being drained,
  // so a result held under backpressure is never overwritten.
  assign w_issue     = (r_state == S_RUN) && (!r_out_valid || i_out_ready);
  assign w_handshake = r_out_valid && i_out_ready;

  // Shared LIF datapath: 32-bit signed product, arithmetic shift back to Q-format.
  assign w_mem_ext = {{8{r_mem[r_n][23]}}, r_mem[r_n]};
  assign w_prod    = w_mem_ext * BETA_S;
  assign w_decay   = 24'(w_prod >>> 7);
  assign w_cur_ext = {{8{r_cur[r_n][15]}}, r_cur[r_n]};
  assign w_next    = w_decay + w_cur_ext - (r_spike_prev[r_n] ? THR_S : 24'sd0);
  assign w_spike   = (w_next >= THR_S);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_next_state = S_CLEAR;
      end
      S_CLEAR: if (w_last_n) w_next_state = S_RUN;
      S_RUN:   if (w_issue && w_last_n && w_last_t) w_next_state = S_FLUSH;
      S_FLUSH: if (w_handshake) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_n            <= '0;
      r_t            <= '0;
      r_spike_prev   <= '0;
      r_out_valid    <= 1'b0;
      r_out_neuron   <= '0;
      r_out_timestep <= '0;
      r_out_spike    <= 1'b0;
      r_out_membrane <= '0;
      r_done         <= 1'b0;
      r_cnt_data     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_cur[i]   <= '0;
        r_mem[i]   <= '0;
        r_count[i] <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_cnt_data <= (int'(i_cnt_addr) < NUM_NEURONS) ? r_count[i_cnt_addr] : '0;
      case (r_state)
        S_IDLE: begin
          // A write in the same cycle as start still lands before the run reads it.
          if (i_cur_we && (int'(i_cur_addr) < NUM_NEURONS)) r_cur[i_cur_addr] <= i_cur_data;
          if (i_start) begin
            r_n <= '0;
            r_t <= '0;
          end
        end
        S_CLEAR: begin
          r_mem[r_n]        <= '0;
          r_spike_prev[r_n] <= 1'b0;
          r_count[r_n]      <= '0;
          r_n               <= w_last_n ? '0 : r_n + 1'b1;
        end
        S_RUN: begin
          if (w_issue) begin
            r_mem[r_n]        <= w_next;
            r_spike_prev[r_n] <= w_spike;
            r_count[r_n]      <= r_count[r_n] + CW'(w_spike);
            r_out_valid       <= 1'b1;
            r_out_neuron      <= r_n;
            r_out_timestep    <= r_t;
            r_out_spike       <= w_spike;
            r_out_membrane    <= w_next;
            if (w_last_n) begin
              r_n <= '0;
              r_t <= r_t + 1'b1;
            end else begin
              r_n <= r_n + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = w_busy;
  assign o_done         = r_done;
  assign o_out_valid    = r_out_valid;
  assign o_out_neuron   = r_out_neuron;
  assign o_out_timestep = r_out_timestep;
  assign o_out_spike    = r_out_spike;
  assign o_out_membrane = r_out_membrane;
  assign o_cnt_data     = r_cnt_data;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb/tb_lif_layer_scheduler.sv - self-checking bench for lif_layer_scheduler
module tb_lif_layer_scheduler;
  localparam int N    = 4;
  localparam int T    = 3;
  localparam int THR  = 8192;
  localparam int BETA = 115;
  localparam int NW   = $clog2(N);
  localparam int TW   = $clog2(T);
  localparam int CW   = $clog2(T + 1);

  logic          clk = 1'b0;
  logic          i_reset, i_cur_we, i_start, i_out_ready;
  logic [NW-1:0] i_cur_addr, i_cnt_addr;
  logic [15:0]   i_cur_data;
  logic          o_busy, o_done, o_out_valid, o_out_spike;
  logic [NW-1:0] o_out_neuron;
  logic [TW-1:0] o_out_timestep;
  logic [23:0]   o_out_membrane;
  logic [CW-1:0] o_cnt_data;

  always #5 clk = ~clk;

  lif_layer_scheduler #(.NUM_NEURONS(N), .NUM_TIMESTEPS(T), .THRESHOLD(THR), .BETA(BETA)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cur_we(i_cur_we), .i_cur_addr(i_cur_addr),
    .i_cur_data(i_cur_data), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_neuron(o_out_neuron),
    .o_out_timestep(o_out_timestep), .o_out_spike(o_out_spike),
    .o_out_membrane(o_out_membrane), .i_cnt_addr(i_cnt_addr), .o_cnt_data(o_cnt_data)
  );

  int errors = 0;
  int checks = 0;

  int cur[N];
  int exp_m[N*T];
  int exp_s[N*T];
  int exp_cnt[N];

  int bn[$];
  int bt[$];
  int bs[$];
  int bm[$];
  int done_count, first_valid_c, stall_bad;
  bit busy_at1, timed_out, done_after_last, done_flags_ok;

  // Reference: straight from the LIF equations, timesteps outer, neurons inner.
  function automatic void model();
    int mem[N];
    int sp[N];
    int dec, nx;
    for (int n = 0; n < N; n++) begin
      mem[n] = 0; sp[n] = 0; exp_cnt[n] = 0;
    end
    for (int t = 0; t < T; t++) begin
      for (int n = 0; n < N; n++) begin
        dec = (mem[n] * BETA) >>> 7;
        nx  = dec + cur[n] - (sp[n] != 0 ? THR : 0);
        exp_m[t*N+n] = nx;
        exp_s[t*N+n] = (nx >= THR) ? 1 : 0;
        sp[n]  = exp_s[t*N+n];
        mem[n] = nx;
        exp_cnt[n] += sp[n];
      end
    end
  endfunction

  function automatic int rand_cur();
    return int'($urandom_range(0, 18000)) - 6000;
  endfunction

  task automatic load_currents();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      i_cur_we = 1'b1; i_cur_addr = NW'(i); i_cur_data = 16'(cur[i]);
    end
    @(negedge clk);
    i_cur_we = 1'b0;
  endtask

  task automatic run_inference(input bit rand_ready, input bit disturb);
    bit prev_stall;
    int pn, pt, ps, pm, last_c;
    bn.delete(); bt.delete(); bs.delete(); bm.delete();
    done_count = 0; first_valid_c = -1; stall_bad = 0; timed_out = 1;
    done_after_last = 0; done_flags_ok = 0; busy_at1 = 0;
    prev_stall = 0; last_c = -10; pn = 0; pt = 0; ps = 0; pm = 0;
    @(negedge clk);
    i_start = 1'b1; i_out_ready = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      i_start = 1'b0; i_cur_we = 1'b0;
      if (disturb && (c == 2 || c == N + 4)) begin
        i_start = 1'b1; i_cur_we = 1'b1; i_cur_addr = NW'(c % N);
        i_cur_data = 16'($urandom_range(0, 20000));
      end
      i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == 1) busy_at1 = o_busy;
      if (o_out_valid && first_valid_c < 0) first_valid_c = c;
      if (prev_stall && !(o_out_valid && int'(o_out_neuron) == pn && int'(o_out_timestep) == pt &&
          int'(o_out_spike) == ps && int'($signed(o_out_membrane)) == pm)) stall_bad++;
      if (o_done) begin
        done_count++;
        done_after_last = (last_c == c - 1);
        done_flags_ok   = !o_busy && !o_out_valid;
        timed_out = 0;
        break;
      end
      if (o_out_valid && i_out_ready) begin
        bn.push_back(int'(o_out_neuron)); bt.push_back(int'(o_out_timestep));
        bs.push_back(int'(o_out_spike));  bm.push_back(int'($signed(o_out_membrane)));
        last_c = c;
      end
      prev_stall = o_out_valid && !i_out_ready;
      pn = int'(o_out_neuron); pt = int'(o_out_timestep);
      ps = int'(o_out_spike);  pm = int'($signed(o_out_membrane));
    end
    i_start = 1'b0; i_cur_we = 1'b0; i_out_ready = 1'b1;
    @(negedge clk);
    if (o_done) done_count++;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_cur_we = 1'b0; i_cur_addr = '0; i_cur_data = '0;
    i_start = 1'b0; i_out_ready = 1'b1; i_cnt_addr = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_out_valid); end
    checks++; if (o_out_membrane !== 24'd0) begin errors++; $display("FAIL reset_membrane got %0d want 0", o_out_membrane); end
    checks++; if (o_cnt_data !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_cnt_data); end
  endtask

  task automatic test_basic();
    for (int n = 0; n < N; n++) cur[n] = 8192;
    load_currents();
    model();
    run_inference(1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy_k1 got %b want 1", busy_at1); end
    checks++; if (first_valid_c != N + 2) begin errors++; $display("FAIL basic_first_valid got %0d want %0d", first_valid_c, N + 2); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_count); end
    checks++; if (!done_after_last || !done_flags_ok) begin errors++; $display("FAIL basic_done_timing got after_last=%0d flags_ok=%0d want 1 1", done_after_last, done_flags_ok); end
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL basic_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bn[i] != i % N || bt[i] != i / N || bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin
          errors++;
          $display("FAIL basic_beat%0d got n%0d t%0d s%0d m%0d want n%0d t%0d s%0d m%0d",
                   i, bn[i], bt[i], bs[i], bm[i], i % N, i / N, exp_s[i], exp_m[i]);
        end
      end
      checks++; if (bm[0] != 8192 || bs[0] != 1) begin errors++; $display("FAIL basic_t0 got m%0d s%0d want m8192 s1", bm[0], bs[0]); end
      checks++; if (bm[N] != 7360 || bs[N] != 0) begin errors++; $display("FAIL basic_t1 got m%0d s%0d want m7360 s0", bm[N], bs[N]); end
      checks++; if (bm[2*N] != 14804 || bs[2*N] != 1) begin errors++; $display("FAIL basic_t2 got m%0d s%0d want m14804 s1", bm[2*N], bs[2*N]); end
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk); i_cnt_addr = NW'(n);
      @(negedge clk);
      checks++; if (o_cnt_data !== CW'(2)) begin errors++; $display("FAIL basic_cnt%0d got %0d want 2", n, o_cnt_data); end
    end
  endtask

  task automatic test_negative();
    cur[0] = 0; cur[1] = -4096; cur[2] = 0; cur[3] = 0;
    load_currents();
    model();
    run_inference(1'b0, 1'b0);
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL neg_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bn[i] != i % N || bt[i] != i / N || bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin
          errors++;
          $display("FAIL neg_beat%0d got n%0d s%0d m%0d want n%0d s%0d m%0d", i, bn[i], bs[i], bm[i], i % N, exp_s[i], exp_m[i]);
        end
      end
      checks++; if (bm[1] != -4096 || bm[N+1] != -7776) begin errors++; $display("FAIL neg_n1 got %0d %0d want -4096 -7776", bm[1], bm[N+1]); end
      checks++; if (bm[2*N] != 0) begin errors++; $display("FAIL neg_n0_t2 got %0d want 0", bm[2*N]); end
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk); i_cnt_addr = NW'(n);
      @(negedge clk);
      checks++; if (o_cnt_data !== '0) begin errors++; $display("FAIL neg_cnt%0d got %0d want 0", n, o_cnt_data); end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < N; n++) cur[n] = rand_cur();
    load_currents();
    model();
    run_inference(1'b1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_bad); end
    checks++; if (done_count != 1 || !done_after_last) begin errors++; $display("FAIL bp_done got pulses=%0d after_last=%0d want 1 1", done_count, done_after_last); end
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL bp_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bn[i] != i % N || bt[i] != i / N || bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin
          errors++;
          $display("FAIL bp_beat%0d got n%0d t%0d s%0d m%0d want n%0d t%0d s%0d m%0d",
                   i, bn[i], bt[i], bs[i], bm[i], i % N, i / N, exp_s[i], exp_m[i]);
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk); i_cnt_addr = NW'(n);
      @(negedge clk);
      checks++; if (o_cnt_data !== CW'(exp_cnt[n])) begin errors++; $display("FAIL bp_cnt%0d got %0d want %0d", n, o_cnt_data, exp_cnt[n]); end
    end
  endtask

  task automatic test_ignored_inputs();
    for (int n = 0; n < N; n++) cur[n] = rand_cur();
    load_currents();
    model();
    run_inference(1'b1, 1'b1);
    checks++; if (done_count != 1) begin errors++; $display("FAIL ign_done got %0d pulses want 1", done_count); end
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL ign_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bn[i] != i % N || bt[i] != i / N || bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin
          errors++;
          $display("FAIL ign_beat%0d got n%0d t%0d s%0d m%0d want n%0d t%0d s%0d m%0d",
                   i, bn[i], bt[i], bs[i], bm[i], i % N, i / N, exp_s[i], exp_m[i]);
        end
      end
    end
    // Rerun with the same buffer: identical results and counts re-cleared, not accumulated.
    run_inference(1'b0, 1'b0);
    checks++;
    if (bm.size() != N*T) begin errors++; $display("FAIL ign_rerun_beats got %0d want %0d", bm.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bm[i] != exp_m[i] || bs[i] != exp_s[i]) begin errors++; $display("FAIL ign_rerun%0d got m%0d want m%0d", i, bm[i], exp_m[i]); end
      end
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk); i_cnt_addr = NW'(n);
      @(negedge clk);
      checks++; if (o_cnt_data !== CW'(exp_cnt[n])) begin errors++; $display("FAIL ign_cnt%0d got %0d want %0d", n, o_cnt_data, exp_cnt[n]); end
    end
  endtask

  task automatic test_reset_midrun();
    for (int n = 0; n < N; n++) cur[n] = rand_cur();
    load_currents();
    @(negedge clk); i_start = 1'b1; i_out_ready = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (N + 4) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got busy%b valid%b done%b want 000", o_busy, o_out_valid, o_done);
    end
    checks++; if (o_cnt_data !== '0) begin errors++; $display("FAIL midreset_cnt got %0d want 0", o_cnt_data); end
    for (int n = 0; n < N; n++) cur[n] = rand_cur();
    load_currents();
    model();
    run_inference(1'b1, 1'b0);
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL midreset_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bn[i] != i % N || bt[i] != i / N || bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin
          errors++;
          $display("FAIL midreset_beat%0d got n%0d t%0d s%0d m%0d want n%0d t%0d s%0d m%0d",
                   i, bn[i], bt[i], bs[i], bm[i], i % N, i / N, exp_s[i], exp_m[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < N; n++) cur[n] = rand_cur();
    load_currents();
    run_inference(1'b0, 1'b0);
    for (int n = 0; n < N; n++) cur[n] = rand_cur() + 3;
    load_currents();
    model();
    run_inference(1'b1, 1'b0);
    checks++;
    if (bn.size() != N*T) begin errors++; $display("FAIL b2b_beats got %0d want %0d", bn.size(), N*T); end
    else begin
      for (int n = 0; n < N; n++) begin
        checks++;
        if (bm[n] != cur[n]) begin errors++; $display("FAIL b2b_t0_n%0d got %0d want %0d", n, bm[n], cur[n]); end
      end
      for (int i = 0; i < N*T; i++) begin
        checks++;
        if (bs[i] != exp_s[i] || bm[i] != exp_m[i]) begin errors++; $display("FAIL b2b_beat%0d got s%0d m%0d want s%0d m%0d", i, bs[i], bm[i], exp_s[i], exp_m[i]); end
      end
    end
    for (int n = 0; n < N; n++) begin
      @(negedge clk); i_cnt_addr = NW'(n);
      @(negedge clk);
      checks++; if (o_cnt_data !== CW'(exp_cnt[n])) begin errors++; $display("FAIL b2b_cnt%0d got %0d want %0d", n, o_cnt_data, exp_cnt[n]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_ignored_inputs();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
